equiv_miscompare_monitor: RTL and testbench
===========================================

# equiv_miscompare_monitor

Downstream consumer of the dual-instance equivalence harness. Each enabled cycle it compares the two 91-bit design outputs (`y_1`, `y_2`), counts cycles and miscompares, and latches the first failing cycle with its XOR difference. It buffers every miscompare record in a small FIFO and drains it over a valid/ready port, so a bench or host can log failures instead of stopping on the first assertion.

## Interface
- `W`, 91: compared output width (bits `W-1:0`).
- `DEPTH`, 4: miscompare record FIFO depth, power of two, ≥2.
- `CNT_W`, 32: width of cycle and miscompare counters.

- `clk`  in  1: sampling clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous clear of counters, first-capture, FIFO, `overflow` and FSM.
- `en`  in  1: compare enable; a cycle is sampled only when `en`=1.
- `y_1`  in  W: output of instance 1.
- `y_2`  in  W: output of instance 2.
- `state`  out  2: FSM state (IDLE=0, RUN=1, FAIL=2).
- `mismatch`  out  1: registered; 1 when the previous sampled cycle miscompared.
- `cycle_count`  out  CNT_W: number of sampled cycles, saturating.
- `mis_count`  out  CNT_W: number of miscompared cycles, saturating.
- `first_valid`  out  1: first miscompare captured.
- `first_cycle`  out  CNT_W: cycle index of the first miscompare.
- `first_diff`  out  W: `y_1 ^ y_2` at the first miscompare.
- `rec_valid`  out  1: FIFO head record available.
- `rec_ready`  in  1: consumer accepts the head record.
- `rec_cycle`  out  CNT_W: cycle index of the head record.
- `rec_diff`  out  W: XOR difference of the head record.
- `overflow`  out  1: sticky; a miscompare was dropped because the FIFO was full.

## Operation
- Cycle index: the value of `cycle_count` before the increment. The first sampled cycle is index 0.
- A sampled cycle miscompares when `y_1 != y_2` (full W-bit compare, no masking).
- FSM:
  - IDLE → RUN on the first edge with `en`=1. That cycle is sampled.
  - RUN → FAIL on the first miscompare.
  - FAIL is held until `clear` or reset. Sampling and counting continue in FAIL.
  - `clear` → IDLE from any state.
- `en`=0 holds the counters and pushes nothing. `mismatch` goes to 0 on the next edge.
- First capture: on the RUN→FAIL edge, `first_valid`←1 and `first_cycle`/`first_diff` are loaded. They are not overwritten afterwards.
- Record FIFO:
  - Every miscompare pushes {cycle index, diff}.
  - When full with no simultaneous pop, the record is dropped, `overflow`←1, and `mis_count` still increments.
  - Pop occurs when `rec_valid && rec_ready`.
  - Push and pop on the same edge while full: both occur, occupancy stays at DEPTH, no overflow.
  - Push and pop on the same edge while empty: the record is written. `rec_valid` rises on the next cycle. No fall-through.
- Counters saturate at all-ones and do not wrap. At saturation, records carry the saturated index.
- `clear` has priority over `en` on the same edge. That sample is discarded.

## Timing
- Reset values (async, `rst_n`=0):
  - `state`=IDLE.
  - `mismatch`, `first_valid`, `rec_valid`, `overflow` = 0.
  - All counters, `first_cycle`, `first_diff`, `rec_cycle`, `rec_diff` = 0.
- Latency is 1 cycle from the sampling edge to `mismatch`, `mis_count`, `cycle_count`, `state` and first-capture.
- `rec_valid` asserts 1 cycle after the push edge.
- `rec_cycle`/`rec_diff` are stable while `rec_valid`=1 and `rec_ready`=0.
- Reset mid-operation takes effect immediately and asynchronously. All state is lost; there is no partial drain.
- Throughput is one sample per cycle and one pop per cycle.

## Structure
- Package `equiv_mon_pkg`:
  - `mon_state_e` enum (IDLE, RUN, FAIL).
  - `mis_rec_t` packed struct {cycle[CNT_W], diff[W]}.
  - Default constants `EQ_W=91`, `EQ_CNT_W=32`.
- Sub-module `equiv_rec_fifo`:
  - Synchronous FIFO of `mis_rec_t`, DEPTH entries.
  - Wrap pointers with an extra MSB for full/empty.
  - Ports: push/pop, full, registered head outputs.
- The top level holds the FSM, comparator, counters and first-capture registers.

## Test plan
- Equal outputs for 100 cycles with `en`=1 → `cycle_count`=100, `mis_count`=0, `state`=RUN, `rec_valid`=0.
- Miscompare at index 5 only, `y_1`=0, `y_2`=1<<90 → `state`=FAIL, `first_cycle`=5, `first_diff`=1<<90. One record is popped, then `rec_valid`=0.
- 6 consecutive miscompares with `rec_ready`=0, DEPTH=4 → `mis_count`=6, `overflow`=1. Records drain with indices 0,1,2,3.
- FIFO full with `rec_ready`=1 and a miscompare each cycle → no overflow, occupancy stays 4, indices are strictly increasing.
- `en` toggled 1,0,1 with a miscompare at the third cycle → that record has index 1 and `cycle_count`=2.
- `rst_n` asserted mid-FAIL with 3 records buffered → all outputs are 0 immediately, `state`=IDLE. The next sample after release is index 0.

Source files
------------

// File: rtl/equiv_mon_pkg.sv
// Shared types and default widths for the equivalence miscompare monitor.
package equiv_mon_pkg;

  localparam int unsigned EQ_W     = 91;
  localparam int unsigned EQ_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [EQ_CNT_W-1:0] cycle;
    logic [EQ_W-1:0]     diff;
  } mis_rec_t;

endpackage

// File: rtl/equiv_rec_fifo.sv
// Miscompare record FIFO: DEPTH entries of mis_rec_t, wrap pointers with an
// extra MSB to tell full from empty. Head is read from registered storage, so
// a record written on an edge is first visible after that edge (no fall-through).
module equiv_rec_fifo
  import equiv_mon_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_clear,
  input  logic     i_push,
  input  mis_rec_t i_rec,
  input  logic     i_pop,
  output logic     o_full,
  output logic     o_valid,
  output mis_rec_t o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  mis_rec_t    r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  // When full, a same-edge pop frees the slot the write lands in.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_full  = w_full;
  assign o_valid = !w_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; clear empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Record storage; reset zeroes it so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !i_clear) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_rec;
    end
  end

endmodule

// File: rtl/equiv_miscompare_monitor.sv
// Compares two design-instance outputs each enabled cycle, counts samples and
// miscompares, latches the first failure and queues every failure record.
// W and CNT_W must match the package record widths.
module equiv_miscompare_monitor
  import equiv_mon_pkg::*;
#(
  parameter int unsigned W     = EQ_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = EQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [W-1:0]     y_1,
  input  logic [W-1:0]     y_2,
  output logic [1:0]       state,
  output logic             mismatch,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] mis_count,
  output logic             first_valid,
  output logic [CNT_W-1:0] first_cycle,
  output logic [W-1:0]     first_diff,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_cycle,
  output logic [W-1:0]     rec_diff,
  output logic             overflow
);

  mon_state_e       r_state;
  mon_state_e       w_state_nxt;
  logic             r_mismatch;
  logic             r_first_valid;
  logic             r_overflow;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_mis_count;
  logic [CNT_W-1:0] r_first_cycle;
  logic [W-1:0]     r_first_diff;

  logic             w_sample;
  logic             w_miscmp;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_rec_valid;
  logic [W-1:0]     w_diff;
  mis_rec_t         w_rec;
  mis_rec_t         w_head;

  assign w_sample = en && !clear;
  assign w_miscmp = (y_1 != y_2);
  assign w_diff   = y_1 ^ y_2;
  assign w_push   = w_sample && w_miscmp;
  assign w_pop    = w_rec_valid && rec_ready;

  // Record carries the pre-increment (possibly saturated) cycle index.
  always_comb begin
    w_rec       = '0;
    w_rec.cycle = r_cycle_count;
    w_rec.diff  = w_diff;
  end

  equiv_rec_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (clear),
    .i_push  (w_push),
    .i_rec   (w_rec),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_valid (w_rec_valid),
    .o_head  (w_head)
  );

  // Next-state: first enabled edge leaves IDLE, any miscompare lands in FAIL.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else if (en) begin
      case (r_state)
        IDLE:    w_state_nxt = w_miscmp ? FAIL : RUN;
        RUN:     w_state_nxt = w_miscmp ? FAIL : RUN;
        FAIL:    w_state_nxt = FAIL;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Saturating counters, registered mismatch flag and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count <= '0;
      r_mis_count   <= '0;
      r_mismatch    <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (clear) begin
      r_cycle_count <= '0;
      r_mis_count   <= '0;
      r_mismatch    <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_mismatch <= w_push;
      if (w_sample && (r_cycle_count != '1))
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      if (w_push && (r_mis_count != '1))
        r_mis_count <= r_mis_count + CNT_W'(1);
      if (w_push && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  // First-failure capture, loaded once until clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_valid <= 1'b0;
      r_first_cycle <= '0;
      r_first_diff  <= '0;
    end else if (clear) begin
      r_first_valid <= 1'b0;
      r_first_cycle <= '0;
      r_first_diff  <= '0;
    end else if (w_push && !r_first_valid) begin
      r_first_valid <= 1'b1;
      r_first_cycle <= r_cycle_count;
      r_first_diff  <= w_diff;
    end
  end

  assign state       = r_state;
  assign mismatch    = r_mismatch;
  assign cycle_count = r_cycle_count;
  assign mis_count   = r_mis_count;
  assign first_valid = r_first_valid;
  assign first_cycle = r_first_cycle;
  assign first_diff  = r_first_diff;
  assign rec_valid   = w_rec_valid;
  assign rec_cycle   = w_head.cycle;
  assign rec_diff    = w_head.diff;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_equiv_miscompare_monitor.sv
// Self-checking bench: a behavioural model tracks counters/FSM, and a
// scoreboard queue holds the records the FIFO is expected to deliver.
module tb_equiv_miscompare_monitor;

  localparam int W     = 91;
  localparam int CW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [CW-1:0] cyc;
    logic [W-1:0]  diff;
  } exp_rec_t;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          en;
  logic [W-1:0]  y_1;
  logic [W-1:0]  y_2;
  logic [1:0]    state;
  logic          mismatch;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] mis_count;
  logic          first_valid;
  logic [CW-1:0] first_cycle;
  logic [W-1:0]  first_diff;
  logic          rec_valid;
  logic          rec_ready;
  logic [CW-1:0] rec_cycle;
  logic [W-1:0]  rec_diff;
  logic          overflow;

  equiv_miscompare_monitor #(
    .W     (W),
    .DEPTH (DEPTH),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .en          (en),
    .y_1         (y_1),
    .y_2         (y_2),
    .state       (state),
    .mismatch    (mismatch),
    .cycle_count (cycle_count),
    .mis_count   (mis_count),
    .first_valid (first_valid),
    .first_cycle (first_cycle),
    .first_diff  (first_diff),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_cycle   (rec_cycle),
    .rec_diff    (rec_diff),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Model state.
  logic [1:0]    m_state;
  logic          m_mismatch;
  logic [CW-1:0] m_cycle;
  logic [CW-1:0] m_mis;
  logic          m_over;
  logic          m_fv;
  logic [CW-1:0] m_fc;
  logic [W-1:0]  m_fd;
  exp_rec_t      exp_q[$];

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd91();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    m_state = 2'd0; m_mismatch = 1'b0; m_cycle = '0; m_mis = '0;
    m_over = 1'b0; m_fv = 1'b0; m_fc = '0; m_fd = '0;
    exp_q.delete();
  endtask

  task automatic check_status();
    check_eq("state", state, m_state);
    check_eq("mismatch", mismatch, m_mismatch);
    check_eq("cycle_count", cycle_count, m_cycle);
    check_eq("mis_count", mis_count, m_mis);
    check_eq("overflow", overflow, m_over);
    check_eq("first_valid", first_valid, m_fv);
    if (m_fv) begin
      check_eq("first_cycle", first_cycle, m_fc);
      check_eq("first_diff", first_diff, m_fd);
    end
  endtask

  // One clock: drive inputs after the falling edge, score the head record if
  // it is being popped, advance the model, then check status after the edge.
  task automatic step(input logic i_en, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic rdy, input logic clr);
    exp_rec_t r;
    logic     mis;
    en = i_en; y_1 = a; y_2 = b; rec_ready = rdy; clear = clr;
    #1;
    check_eq("rec_valid", rec_valid, exp_q.size() != 0);
    if (clr) begin
      model_reset();
    end else begin
      if (rdy && exp_q.size() != 0) begin
        r = exp_q.pop_front();
        check_eq("rec_cycle", rec_cycle, r.cyc);
        check_eq("rec_diff", rec_diff, r.diff);
      end
      mis = (a != b);
      m_mismatch = i_en && mis;
      if (i_en) begin
        if (mis) begin
          if (exp_q.size() < DEPTH) begin
            r.cyc = m_cycle; r.diff = a ^ b;
            exp_q.push_back(r);
          end else begin
            m_over = 1'b1;
          end
          if (!m_fv) begin
            m_fv = 1'b1; m_fc = m_cycle; m_fd = a ^ b;
          end
          if (m_mis != '1) m_mis = m_mis + 1;
          m_state = 2'd2;
        end else if (m_state == 2'd0) begin
          m_state = 2'd1;
        end
        if (m_cycle != '1) m_cycle = m_cycle + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_status();
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("drained", exp_q.size(), 0);
  endtask

  logic [W-1:0] a;
  logic [W-1:0] top_bit;

  initial begin
    rst_n = 1'b0; clear = 1'b0; en = 1'b0; y_1 = '0; y_2 = '0; rec_ready = 1'b0;
    top_bit = '0; top_bit[W-1] = 1'b1;
    model_reset();
    #13;
    check_eq("rst_state", state, 0);
    check_eq("rst_rec_valid", rec_valid, 0);
    check_eq("rst_rec_diff", rec_diff, 0);
    check_eq("rst_first_diff", first_diff, 0);
    check_status();
    @(negedge clk);
    rst_n = 1'b1;

    // Equal outputs for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      a = rnd91();
      step(1'b1, a, a, 1'b0, 1'b0);
    end
    check_eq("eq100_cycles", cycle_count, 100);
    check_eq("eq100_mis", mis_count, 0);
    check_eq("eq100_state", state, 1);
    check_eq("eq100_rec_valid", rec_valid, 0);

    // Single miscompare at index 5 in the top bit.
    step(1'b1, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, '0, (i == 5) ? top_bit : '0, 1'b0, 1'b0);
    check_eq("one_state", state, 2);
    check_eq("one_first_cycle", first_cycle, 5);
    check_eq("one_first_diff", first_diff, top_bit);
    drain(4);
    check_eq("one_empty", rec_valid, 0);

    // Six consecutive miscompares into a 4-deep FIFO with no consumer.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      a = rnd91();
      step(1'b1, a, a ^ rnd91() ^ top_bit, 1'b0, 1'b0);
    end
    check_eq("ovf_mis", mis_count, 6);
    check_eq("ovf_flag", overflow, 1);
    drain(8);

    // Full FIFO with a consumer and a miscompare every cycle.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, '0, rnd91() | 91'd1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, '0, rnd91() | 91'd1, 1'b1, 1'b0);
      check_eq("full_occ", exp_q.size(), DEPTH);
    end
    check_eq("full_no_ovf", overflow, 0);
    drain(8);

    // Enable pattern 1,0,1 with the miscompare on the third cycle.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 91'd3, 1'b0, 1'b0);
    step(1'b1, '0, 91'd7, 1'b0, 1'b0);
    check_eq("en_rec_idx", rec_cycle, 1);
    check_eq("en_cycles", cycle_count, 2);
    drain(4);

    // Clear concurrent with a miscompare discards that sample.
    step(1'b1, '0, 91'd1, 1'b0, 1'b1);
    check_eq("clr_prio_mis", mis_count, 0);

    // Asynchronous reset in FAIL with three records buffered.
    for (int i = 0; i < 3; i++) step(1'b1, '0, rnd91() | 91'd2, 1'b0, 1'b0);
    check_eq("pre_rst_state", state, 2);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_state", state, 0);
    check_eq("arst_rec_valid", rec_valid, 0);
    check_eq("arst_rec_cycle", rec_cycle, 0);
    check_eq("arst_first_diff", first_diff, 0);
    check_status();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, '0, 91'd5, 1'b0, 1'b0);
    check_eq("post_rst_idx", rec_cycle, 0);
    drain(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
